// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are registered and held until the next completed operation.
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             fits;
    logic             last;

    // The partial remainder is always below the divisor, so one extra
    // bit keeps the shifted value and the subtraction free of overflow.
    always_comb begin
        shifted  = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs_q});
        rem_next = fits ? (shifted - {1'b0, dvs_q}) : shifted;
        quo_next = {quo_q[WIDTH-2:0], fits};
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (divisor == '0) begin
                    state_d     = S_DONE;
                    quotient_d  = '1;
                    remainder_d = dividend;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    quo_d   = '0;
                end
            end
            S_CALC: begin
                dvd_d = dvd_q << 1;
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    quotient_d  = quo_next;
                    remainder_d = rem_next[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
